trng_conditioner: RTL and testbench
===================================

// Module: trng_conditioner
// PURPOSE
// Parametrised entropy conditioner between raw ring/LFSR entropy sources and the post-processing/serial path.
// Compresses NSRC parallel sampled words into OUT_WIDTH-bit words with a configurable-polynomial CRC.
// Runs a warm-up discard and a repetition-count health test on every compressed word.
// Buffers accepted words in a FIFO and presents them on a valid/ready interface.
// PARAMETERS
// NSRC            1      number of parallel entropy sources
// SRC_WIDTH       32     sampled bits per source
// OUT_WIDTH       8      compressed word width (>=2)
// POLY            8'h07  CRC feedback polynomial, OUT_WIDTH bits (x^8+x^2+x+1 default)
// SAMPLES_PER_OUT 1      accepted sample cycles folded into one output word (>=1)
// WARMUP          16     completed words discarded after reset (0 = none)
// RCT_CUTOFF      8      identical consecutive words that trip the alarm (>=2)
// FIFO_DEPTH      16     output FIFO entries, power of 2
// PORTS
// i_clk           in   1                     clock
// i_reset         in   1                     synchronous, active-high reset
// i_sample_valid  in   1                     i_sampled holds a new sample this cycle
// i_sampled       in   NSRC*SRC_WIDTH        raw samples, bit MSB first into CRC
// o_dat           out  OUT_WIDTH             FIFO head word
// o_valid         out  1                     FIFO not empty and no alarm
// i_ready         in   1                     consumer pops head when o_valid&i_ready
// o_level         out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
// o_warm          out  1                     warm-up finished
// o_alarm         out  1                     sticky health-test failure
// o_drop_cnt      out  8                     saturating count of words lost to FIFO full
// BEHAVIOUR
// - Reset: o_dat=0, o_valid=0, o_level=0, o_alarm=0, o_drop_cnt=0, o_warm=(WARMUP==0); CRC state, sample cnt, run cnt cleared.
// - CRC per bit d, MSB of i_sampled first: fb=c[MSB]^d; c={c<<1}^(fb?POLY:0). State is 0 at start of each word (words independent).
// - Sample cnt increments on i_sample_valid; on the SAMPLES_PER_OUT-th sample the word completes at that edge (CRC includes that sample), cnt wraps to 0.
// - No samples consumed (cnt and CRC frozen) while o_alarm=1.
// - Completed word W: health test first, then warm-up, then push.
// - RCT: first word after reset run=1; W==previous word -> run+1, else run=1; run reaching RCT_CUTOFF sets o_alarm at that edge, W not pushed.
// - Warm-up: while fewer than WARMUP words completed, W discarded; o_warm rises on the edge completing word WARMUP.
// - Push: if FIFO not full, or full with a pop on the same edge, W written; else dropped, o_drop_cnt+1 saturating at 255.
// - Latency: W visible on o_dat with o_valid=1 the cycle after its completing edge when FIFO was empty.
// - Pop on o_valid&i_ready; simultaneous push+pop leaves o_level unchanged; empty->no pop, o_valid=0.
// - Alarm: o_alarm sticky until i_reset; on setting, FIFO flushed (o_level=0, o_valid=0 next cycle); o_drop_cnt held.
// - Reset mid-word or mid-transfer: partial word and FIFO contents discarded, warm-up restarts.
// CONFIGURATION
// - TRNG_COND_RAW_BYPASS_EN defined: adds input i_raw_mode (1 bit). When 1, each accepted sample pushes
//   i_sampled[OUT_WIDTH-1:0] directly as a completed word (no CRC, SAMPLES_PER_OUT ignored); RCT, warm-up, FIFO unchanged.
//   Any change of i_raw_mode clears sample cnt and CRC state; the partial word is discarded.
// - Not defined: port absent, conditioned path always used.
// TESTING
// - NSRC=1,SRC_WIDTH=8,WARMUP=0,SPO=1: sample 8'h01 -> o_dat=8'h07 next cycle; sample 8'h80 -> 8'h89.
// - SPO=2: samples 8'h00,8'h01 -> single word 8'h07 after 2nd sample; o_level=1, not after 1st.
// - WARMUP=2: samples 8'h01,8'h02,8'h03 -> only CRC(8'h03)=8'h09 reaches FIFO; o_warm rises after 2nd sample.
// - RCT_CUTOFF=4,WARMUP=0,i_ready=0: sample 8'h55 x4 -> o_level=3 after 3, o_alarm=1 on 4th, o_level=0, later samples ignored.
// - FIFO_DEPTH=4,i_ready=0: 6 distinct samples -> o_level=4, o_drop_cnt=2; then i_ready=1 -> first 4 words in order.
// - Bypass (macro on, i_raw_mode=1): sample 8'hA5 -> o_dat=8'hA5; toggling mid-word with SPO=2 discards partial word.

Source files
------------

// File: rtl/trng_conditioner_if.sv
// trng_conditioner_if: sample input, FIFO output handshake and status signals
// of the entropy conditioner. The conditioner takes the slave modport. The
// producer/consumer side (sampler plus post-processing) takes the master modport.
// When TRNG_COND_RAW_BYPASS_EN is defined, the interface also carries i_raw_mode.
interface trng_conditioner_if #(
  parameter int NSRC       = 1,
  parameter int SRC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                          i_sample_valid;
  logic [NSRC*SRC_WIDTH-1:0]     i_sampled;
  logic [OUT_WIDTH-1:0]          o_dat;
  logic                          o_valid;
  logic                          i_ready;
  logic [$clog2(FIFO_DEPTH):0]   o_level;
  logic                          o_warm;
  logic                          o_alarm;
  logic [7:0]                    o_drop_cnt;
`ifdef TRNG_COND_RAW_BYPASS_EN
  logic                          i_raw_mode;

  modport master (
    output i_sample_valid, i_sampled, i_ready, i_raw_mode,
    input  o_dat, o_valid, o_level, o_warm, o_alarm, o_drop_cnt
  );
  modport slave (
    input  i_sample_valid, i_sampled, i_ready, i_raw_mode,
    output o_dat, o_valid, o_level, o_warm, o_alarm, o_drop_cnt
  );
`else
  modport master (
    output i_sample_valid, i_sampled, i_ready,
    input  o_dat, o_valid, o_level, o_warm, o_alarm, o_drop_cnt
  );
  modport slave (
    input  i_sample_valid, i_sampled, i_ready,
    output o_dat, o_valid, o_level, o_warm, o_alarm, o_drop_cnt
  );
`endif
endinterface

// File: rtl/trng_conditioner.sv
// trng_conditioner: folds raw entropy samples into CRC-compressed words and
// applies the warm-up discard and the repetition-count health test. Accepted
// words are buffered in a FIFO for a valid/ready consumer.
// Optional feature macro: TRNG_COND_RAW_BYPASS_EN. It adds raw mode, where
// each sample's low OUT_WIDTH bits become a word directly.
//
// state      | meaning
// ST_WARMUP  | completed words are health-tested, then discarded
// ST_RUN     | completed words are health-tested, then pushed to the FIFO
// ST_ALARM   | health test tripped; sampling frozen, FIFO empty, until reset
module trng_conditioner #(
  parameter int                   NSRC            = 1,
  parameter int                   SRC_WIDTH       = 32,
  parameter int                   OUT_WIDTH       = 8,
  parameter logic [OUT_WIDTH-1:0] POLY            = 8'h07,
  parameter int                   SAMPLES_PER_OUT = 1,
  parameter int                   WARMUP          = 16,
  parameter int                   RCT_CUTOFF      = 8,
  parameter int                   FIFO_DEPTH      = 16
) (
  input logic               i_clk,
  input logic               i_reset,
  trng_conditioner_if.slave bus
);
  localparam int IN_W  = NSRC * SRC_WIDTH;
  localparam int CNT_W = (SAMPLES_PER_OUT > 1) ? $clog2(SAMPLES_PER_OUT) : 1;
  localparam int RUN_W = $clog2(RCT_CUTOFF + 1);
  localparam int WRM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_OUT - 1);
  localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(RCT_CUTOFF);
  localparam logic [WRM_W-1:0] WRM_LAST = WRM_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_WARMUP, ST_RUN, ST_ALARM} state_t;

  state_t               state_q, state_d;
  logic                 warm_q;
  logic [WRM_W-1:0]     warm_cnt_q;
  logic [CNT_W-1:0]     cnt_q, cnt_base;
  logic [OUT_WIDTH-1:0] crc_q, crc_base, crc_new;
  logic [OUT_WIDTH-1:0] prev_q, word;
  logic                 have_prev_q;
  logic [RUN_W-1:0]     run_q, run_new;
  logic                 raw_mode, mode_chg;
  logic                 accept, word_done, trip;
  logic                 push_req, warm_inc;
  logic                 pop, push_ok, drop, full;
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [LVL_W-1:0]     count_q;
  logic [7:0]           drop_q;
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];

  // MSB-first bit-serial CRC over one whole sample, continuing from c_in
  function automatic logic [OUT_WIDTH-1:0] crc_fold(input logic [OUT_WIDTH-1:0] c_in,
                                                    input logic [IN_W-1:0] d);
    logic [OUT_WIDTH-1:0] c;
    logic                 fb;
    c = c_in;
    for (int i = IN_W - 1; i >= 0; i--) begin
      fb = c[OUT_WIDTH-1] ^ d[i];
      c  = (c << 1) ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

`ifdef TRNG_COND_RAW_BYPASS_EN
  logic raw_q;
  assign raw_mode = bus.i_raw_mode;
  assign mode_chg = raw_mode ^ raw_q;

  // remember the previous mode so a change can discard the partial word
  always_ff @(posedge i_clk) begin
    if (i_reset) raw_q <= 1'b0;
    else         raw_q <= raw_mode;
  end
`else
  assign raw_mode = 1'b0;
  assign mode_chg = 1'b0;
`endif

  // word assembly and repetition-count evaluation for the current sample
  always_comb begin
    cnt_base  = mode_chg ? '0 : cnt_q;
    crc_base  = mode_chg ? '0 : crc_q;
    accept    = bus.i_sample_valid & (state_q != ST_ALARM);
    crc_new   = crc_fold(crc_base, bus.i_sampled);
    word_done = accept & (raw_mode | (cnt_base == CNT_LAST));
    word      = raw_mode ? bus.i_sampled[OUT_WIDTH-1:0] : crc_new;
    run_new   = (have_prev_q && (word == prev_q)) ? run_q + 1'b1 : RUN_W'(1);
    trip      = word_done & (run_new >= RUN_TRIP);
  end

  // next state plus the word disposition (discard during warm-up, push when running)
  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    warm_inc = 1'b0;
    case (state_q)
      ST_WARMUP: begin
        if (trip) begin
          state_d = ST_ALARM;
        end else if (word_done) begin
          warm_inc = 1'b1;
          if (warm_cnt_q == WRM_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (trip) state_d = ST_ALARM;
        else      push_req = word_done;
      end
      default: state_d = ST_ALARM;
    endcase
  end

  // state register, warm-up progress and the sampling/health-test history
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
      warm_q      <= (WARMUP == 0);
      warm_cnt_q  <= '0;
      cnt_q       <= '0;
      crc_q       <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      run_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_WARMUP && state_d == ST_RUN) warm_q <= 1'b1;
      if (warm_inc) warm_cnt_q <= warm_cnt_q + 1'b1;
      if (accept) begin
        if (word_done) begin
          cnt_q <= '0;
          crc_q <= '0;
        end else begin
          cnt_q <= cnt_base + 1'b1;
          crc_q <= crc_new;
        end
      end else if (mode_chg) begin
        cnt_q <= '0;
        crc_q <= '0;
      end
      if (word_done) begin
        prev_q      <= word;
        have_prev_q <= 1'b1;
        run_q       <= run_new;
      end
    end
  end

  assign full    = (count_q == LVL_FULL);
  assign pop     = bus.o_valid & bus.i_ready;
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & ~push_ok;

  // FIFO pointers and occupancy; an alarm empties the FIFO
  always_ff @(posedge i_clk) begin
    if (i_reset || trip) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage, no reset needed since reads are gated by occupancy
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= word;
  end

  // saturating count of words lost to a full FIFO
  always_ff @(posedge i_clk) begin
    if (i_reset)                     drop_q <= '0;
    else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
  end

  assign bus.o_dat      = (count_q != '0) ? mem[rd_ptr] : '0;
  assign bus.o_valid    = (count_q != '0) & (state_q != ST_ALARM);
  assign bus.o_level    = count_q;
  assign bus.o_warm     = warm_q;
  assign bus.o_alarm    = (state_q == ST_ALARM);
  assign bus.o_drop_cnt = drop_q;
endmodule

// File: tb/tb_trng_conditioner.sv
// tb_trng_conditioner: directed and randomized checks of trng_conditioner
// (8-bit samples, two samples per word, two warm-up words, cutoff 4, depth 4).
// A queue-based reference model built from the behavioural rules predicts every
// output after each clock edge.
module tb_trng_conditioner;
  localparam int         SPO   = 2;
  localparam int         WU    = 2;
  localparam int         CUT   = 4;
  localparam int         DEPTH = 4;
  localparam logic [7:0] POLY  = 8'h07;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  trng_conditioner_if #(.NSRC(1), .SRC_WIDTH(8), .OUT_WIDTH(8), .FIFO_DEPTH(DEPTH)) bus ();

  trng_conditioner #(
    .NSRC(1), .SRC_WIDTH(8), .OUT_WIDTH(8), .POLY(POLY), .SAMPLES_PER_OUT(SPO),
    .WARMUP(WU), .RCT_CUTOFF(CUT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0] m_q[$];
  logic [7:0] m_part[$];
  int         m_done;
  logic [7:0] m_prev;
  bit         m_have_prev;
  int         m_run;
  bit         m_alarm;
  int         m_drop;
  logic       m_raw;

  function automatic logic [7:0] crc_of(input logic [7:0] s[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (s[k])
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ s[k][b];
        c  = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
      end
    return c;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_part.delete();
    m_done = 0; m_prev = 8'h00; m_have_prev = 0; m_run = 0;
    m_alarm = 0; m_drop = 0; m_raw = 1'b0;
  endtask

  task automatic model_edge(input logic sv, input logic [7:0] d, input logic rdy, input logic rm);
    bit         pop, have_word;
    logic [7:0] w;
    pop = !m_alarm && (m_q.size() > 0) && rdy;
    have_word = 0;
    w = 8'h00;
    if (rm !== m_raw) m_part.delete();
    m_raw = rm;
    if (sv && !m_alarm) begin
      if (rm) begin
        w = d; have_word = 1;
      end else begin
        m_part.push_back(d);
        if (m_part.size() == SPO) begin
          w = crc_of(m_part); have_word = 1;
          m_part.delete();
        end
      end
    end
    if (have_word) begin
      m_run = (m_have_prev && w == m_prev) ? m_run + 1 : 1;
      m_prev = w; m_have_prev = 1;
      if (m_run >= CUT) begin
        m_alarm = 1;
        m_q.delete();
        return;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (have_word) begin
      if (m_done < WU) m_done++;
      else if (m_q.size() < DEPTH) m_q.push_back(w);
      else if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("o_valid",    32'(bus.o_valid),    32'(m_q.size() > 0 && !m_alarm));
    chk("o_dat",      32'(bus.o_dat),      (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
    chk("o_level",    32'(bus.o_level),    32'(m_q.size()));
    chk("o_warm",     32'(bus.o_warm),     32'(m_done >= WU));
    chk("o_alarm",    32'(bus.o_alarm),    32'(m_alarm));
    chk("o_drop_cnt", 32'(bus.o_drop_cnt), 32'(m_drop));
  endtask

  task automatic step(input logic rst_in, input logic sv, input logic [7:0] d,
                      input logic rdy, input logic rm);
    rst = rst_in;
    bus.i_sample_valid = sv;
    bus.i_sampled = d;
    bus.i_ready = rdy;
`ifdef TRNG_COND_RAW_BYPASS_EN
    bus.i_raw_mode = rm;
`endif
    @(posedge clk);
    if (rst_in) model_reset();
    else        model_edge(sv, d, rdy, rm);
    #1;
    check_outputs();
  endtask

  task automatic samp(input logic [7:0] d, input logic rdy);
    step(1'b0, 1'b1, d, rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic rand_samp(input logic rdy);
    logic [31:0] r;
    r = $urandom;
    samp(r[7:0], rdy);
  endtask

  initial begin
    logic [31:0] r;
    model_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_dat",   32'(bus.o_dat), 32'h0);
    chk("reset_valid", 32'(bus.o_valid), 32'h0);
    chk("reset_level", 32'(bus.o_level), 32'h0);
    chk("reset_warm",  32'(bus.o_warm), 32'h0);
    chk("reset_alarm", 32'(bus.o_alarm), 32'h0);
    chk("reset_drop",  32'(bus.o_drop_cnt), 32'h0);

    // warm-up: two words discarded
    samp(8'h11, 1'b0); samp(8'h22, 1'b0); samp(8'h33, 1'b0);
    chk("warm_before", 32'(bus.o_warm), 32'h0);
    samp(8'h44, 1'b0);
    chk("warm_after", 32'(bus.o_warm), 32'h1);
    chk("warm_level", 32'(bus.o_level), 32'h0);

    // two samples fold into one word
    samp(8'h00, 1'b0);
    chk("spo_half_level", 32'(bus.o_level), 32'h0);
    samp(8'h01, 1'b0);
    chk("spo_level", 32'(bus.o_level), 32'h1);
    chk("spo_dat",   32'(bus.o_dat), 32'h07);
    chk("spo_valid", 32'(bus.o_valid), 32'h1);
    repeat (3) idle(1'b1);

    // randomized traffic with occasional resets
    repeat (400) begin
      r = $urandom;
      step(r[15:8] == 8'h00, r[17:16] != 2'b00, r[7:0], r[18], 1'b0);
    end

    // reset in the middle of a word restarts warm-up
    samp(8'hAA, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("midreset_warm", 32'(bus.o_warm), 32'h0);
    repeat (4) rand_samp(1'b0);
    chk("rewarm", 32'(bus.o_warm), 32'h1);

    // six words into a depth-4 FIFO: two dropped, then drain in order
    repeat (12) rand_samp(1'b0);
    chk("full_level", 32'(bus.o_level), 32'h4);
    chk("full_drop",  32'(bus.o_drop_cnt), 32'h2);
    repeat (4) idle(1'b1);
    chk("drained_level", 32'(bus.o_level), 32'h0);

    // drop counter saturation
    repeat (600) rand_samp(1'b0);
    chk("drop_sat", 32'(bus.o_drop_cnt), 32'hFF);
    repeat (5) idle(1'b1);

    // repetition-count test: four identical words trip the alarm
    samp(8'h00, 1'b1); samp(8'h01, 1'b1);
    repeat (2) idle(1'b1);
    repeat (3) begin samp(8'h00, 1'b0); samp(8'h55, 1'b0); end
    chk("rct_level3", 32'(bus.o_level), 32'h3);
    chk("rct_noalarm", 32'(bus.o_alarm), 32'h0);
    samp(8'h00, 1'b0); samp(8'h55, 1'b0);
    chk("rct_alarm", 32'(bus.o_alarm), 32'h1);
    chk("rct_flush", 32'(bus.o_level), 32'h0);
    chk("rct_valid", 32'(bus.o_valid), 32'h0);
    repeat (6) rand_samp(1'b1);
    chk("rct_frozen", 32'(bus.o_level), 32'h0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("alarm_cleared", 32'(bus.o_alarm), 32'h0);

`ifdef TRNG_COND_RAW_BYPASS_EN
    // raw bypass: each sample is a word; mode changes discard partial words
    step(1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
    chk("raw_dat", 32'(bus.o_dat), 32'hA5);
    step(1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    chk("raw_toggle_dat", 32'(bus.o_dat), 32'h07);
    chk("raw_toggle_level", 32'(bus.o_level), 32'h1);
    repeat (200) begin
      r = $urandom;
      step(1'b0, r[9:8] != 2'b00, r[7:0], r[10], r[13:11] == 3'b000);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
